mc_longop_sequencer: RTL and testbench
======================================

# mc_longop_sequencer

Issue and completion controller for the shared multi-cycle arithmetic unit that executes MUL, DIV, VMUL, VDIV, FADD, FSUB, FMUL and FDIV. It sits between decode and the iterative unit. It detects long-latency opcodes in the incoming instruction word (IW), starts the unit and counts the per-opcode latency. It stalls decode on structural or register hazards and issues a one-cycle write-back strobe to the register file.

## Interface
Parameters:
- MUL_LAT, 4, cycles from Unit_start to WB_en for MUL/VMUL
- DIV_LAT, 16, same for DIV/VDIV
- FADD_LAT, 3, same for FADD/FSUB
- FMUL_LAT, 5, same for FMUL
- FDIV_LAT, 20, same for FDIV
- All latencies are legal in 2..31.

Ports:
- Clk_pin  in  1  clock; all state changes on its rising edge
- Resetn_pin  in  1  asynchronous, active-low reset
- IW_in  in  16  instruction word from decode; [15:10] opcode, [9:5] Ri, [4:0] Rj
- IW_valid  in  1  IW_in is live this cycle
- Flush  in  1  synchronous abort of the in-flight operation
- Stall  out  1  combinational; decode must hold IW_in
- Busy  out  1  registered; high when state is not IDLE
- Unit_start  out  1  one-cycle start pulse to the arithmetic unit
- Unit_abort  out  1  one-cycle abort pulse to the arithmetic unit
- Unit_op  out  3  opcode select: 0 MUL, 1 DIV, 2 VMUL, 3 VDIV, 4 FADD, 5 FSUB, 6 FMUL, 7 FDIV
- Unit_rd  out  5  captured Ri (destination and first source)
- Unit_rs  out  5  captured Rj (second source)
- WB_en  out  1  one-cycle write-back strobe
- WB_rd  out  5  destination register for WB_en

## Operation
- Long-op opcodes: 101010 MUL, 101011 DIV, 110010 VMUL, 110011 VDIV, 001000 FADD, 001001 FSUB, 001010 FMUL, 001011 FDIV. All other opcodes pass through untouched.
- IW_in = 16'hFFFF is a pipeline bubble. It is treated as IW_valid = 0.
- FSM states: IDLE, RUN, WB.
- IDLE:
  - Accept when IW_valid, the opcode is a long op, and Flush = 0.
  - On accept: capture Unit_op, Unit_rd = IW[9:5] and Unit_rs = IW[4:0]; pulse Unit_start; load cnt = LAT-2; go to RUN.
- RUN:
  - If cnt = 0, go to WB; otherwise decrement cnt.
- WB:
  - WB_en = 1 and WB_rd = Unit_rd for exactly this cycle; go to IDLE.
- Hazard and stall rule: Stall = IW_valid AND state ≠ IDLE AND (opcode is a long op OR IW[9:5] = Unit_rd OR IW[4:0] = Unit_rd).
  - Both register fields are compared for every opcode, which is conservative: immediates and JMP conditions can false-stall.
  - Stall is still asserted during the WB cycle.
- Flush:
  - In RUN or WB: go to IDLE next cycle, pulse Unit_abort, and suppress WB_en in that cycle (WB_en is registered-gated by Flush).
  - In IDLE: blocks acceptance in the same cycle. No Unit_start and no Unit_abort.
- Unit_rd, Unit_rs and Unit_op hold their values until the next accept.
- cnt is 5 bits wide; LAT-2 never underflows because every LAT is at least 2.

## Timing
- Reset (asynchronous, Resetn_pin = 0):
  - State IDLE, cnt = 0.
  - Busy, Unit_start, Unit_abort and WB_en all 0.
  - Unit_op, Unit_rd, Unit_rs and WB_rd all 0.
  - Stall = 0 because state is IDLE.
- Reset mid-operation aborts silently: no WB_en and no Unit_abort. The unit is expected to share Resetn_pin.
- With the accept cycle as t:
  - Unit_start is high in t.
  - Busy rises at t+1.
  - WB_en is high in exactly t+LAT.
  - Busy falls at t+LAT+1.
- Back-to-back long ops: the second is accepted no earlier than t+LAT+1, so long-op throughput is one per LAT+1 cycles.
- Unit_start and Unit_abort are never high in the same cycle.
- WB_en and Unit_abort are never high in the same cycle.

## Test plan
- MUL R3, R4 (IW 0xA864) accepted at t:
  - Unit_start at t, Unit_op = 0, Unit_rd = 3, Unit_rs = 4.
  - WB_en at t+4 with WB_rd = 3.
  - Busy high from t+1 to t+4.
- FDIV R1, R2 at t, then ADD R5, R6 at t+1:
  - ADD is not stalled.
  - WB_en at t+20.
- FADD R7, R8 in flight; present ADD R9, R7 at t+1:
  - Stall = 1 through the WB cycle t+3.
  - Stall = 0 at t+4.
- DIV R2, R3 in flight; present a second MUL:
  - Stall = 1 until the DIV write-back completes.
  - MUL is accepted at t+17 with Unit_start pulsed.
- Flush at t+2 of a DIV:
  - Unit_abort pulses at t+2.
  - IDLE at t+3, with no WB_en at any time.
  - Flush asserted together with a valid MUL in IDLE gives no Unit_start.
- Resetn_pin low at t+5 of FDIV:
  - All outputs are 0 immediately, asynchronously.
  - No WB_en after release.
  - IW 0xFFFF in any state gives no accept and no stall.

Source files
------------

// File: rtl/mc_longop_sequencer.sv
// Issue/completion controller for the shared multi-cycle arithmetic unit.
// Starts long ops, counts their latency, stalls decode on hazards and strobes write-back.
module mc_longop_sequencer #(
  parameter int unsigned MUL_LAT  = 32'd4,
  parameter int unsigned DIV_LAT  = 32'd16,
  parameter int unsigned FADD_LAT = 32'd3,
  parameter int unsigned FMUL_LAT = 32'd5,
  parameter int unsigned FDIV_LAT = 32'd20
) (
  input  logic        Clk_pin,
  input  logic        Resetn_pin,
  input  logic [15:0] IW_in,
  input  logic        IW_valid,
  input  logic        Flush,
  output logic        Stall,
  output logic        Busy,
  output logic        Unit_start,
  output logic        Unit_abort,
  output logic [2:0]  Unit_op,
  output logic [4:0]  Unit_rd,
  output logic [4:0]  Unit_rs,
  output logic        WB_en,
  output logic [4:0]  WB_rd
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic [4:0] rd_q, rd_d;
  logic [4:0] rs_q, rs_d;
  logic       busy_q, busy_d;

  logic [5:0] opc_s;
  logic       iw_live_s;
  logic       long_s;
  logic       accept_s;
  logic [2:0] op_sel_s;

  function automatic logic is_long_op(input logic [5:0] opc);
    case (opc)
      6'b101010, 6'b101011, 6'b110010, 6'b110011,
      6'b001000, 6'b001001, 6'b001010, 6'b001011: is_long_op = 1'b1;
      default:                                     is_long_op = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] op_select(input logic [5:0] opc);
    case (opc)
      6'b101010: op_select = 3'd0;
      6'b101011: op_select = 3'd1;
      6'b110010: op_select = 3'd2;
      6'b110011: op_select = 3'd3;
      6'b001000: op_select = 3'd4;
      6'b001001: op_select = 3'd5;
      6'b001010: op_select = 3'd6;
      6'b001011: op_select = 3'd7;
      default:   op_select = 3'd0;
    endcase
  endfunction

  // The counter is preloaded with LAT-2: one cycle is the accept, one is the WB state.
  function automatic logic [4:0] lat_load(input logic [2:0] sel);
    case (sel)
      3'd0, 3'd2: lat_load = 5'(MUL_LAT - 32'd2);
      3'd1, 3'd3: lat_load = 5'(DIV_LAT - 32'd2);
      3'd4, 3'd5: lat_load = 5'(FADD_LAT - 32'd2);
      3'd6:       lat_load = 5'(FMUL_LAT - 32'd2);
      3'd7:       lat_load = 5'(FDIV_LAT - 32'd2);
      default:    lat_load = 5'd0;
    endcase
  endfunction

  // Decode the incoming word; an all-ones word is a bubble and never counts as live.
  always_comb begin
    opc_s     = IW_in[15:10];
    iw_live_s = IW_valid & (IW_in != 16'hFFFF);
    long_s    = is_long_op(opc_s);
    op_sel_s  = op_select(opc_s);
    accept_s  = Resetn_pin & iw_live_s & long_s & ~Flush & (state_q == ST_IDLE);
  end

  // Next-state, latency counter and operand capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_RUN;
          cnt_d   = lat_load(op_sel_s);
          op_d    = op_sel_s;
          rd_d    = IW_in[9:5];
          rs_d    = IW_in[4:0];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (Flush) begin
          state_d = ST_IDLE;
          cnt_d   = 5'd0;
        end else if (cnt_q == 5'd0) begin
          state_d = ST_WB;
        end else begin
          cnt_d   = cnt_q - 5'd1;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 5'd0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and captured-operand registers.
  always_ff @(posedge Clk_pin or negedge Resetn_pin) begin
    if (!Resetn_pin) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 3'd0;
      rd_q    <= 5'd0;
      rs_q    <= 5'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      busy_q  <= busy_d;
    end
  end

  // Unit operand outputs show the new fields already in the accept cycle, then hold.
  always_comb begin
    Busy       = busy_q;
    Unit_start = accept_s;
    Unit_abort = Flush & (state_q != ST_IDLE);
    WB_en      = (state_q == ST_WB) & ~Flush;
    WB_rd      = WB_en ? rd_q : 5'd0;
    Stall      = iw_live_s & (state_q != ST_IDLE) &
                 (long_s | (IW_in[9:5] == rd_q) | (IW_in[4:0] == rd_q));
    if (accept_s) begin
      Unit_op = op_sel_s;
      Unit_rd = IW_in[9:5];
      Unit_rs = IW_in[4:0];
    end else begin
      Unit_op = op_q;
      Unit_rd = rd_q;
      Unit_rs = rs_q;
    end
  end

endmodule

// File: tb/tb_mc_longop_sequencer.sv
// Directed bench for mc_longop_sequencer: a cycle-count model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_mc_longop_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] iw_in;
  logic        iw_valid;
  logic        flush;
  logic        stall, busy, unit_start, unit_abort, wb_en;
  logic [2:0]  unit_op;
  logic [4:0]  unit_rd, unit_rs, wb_rd;

  int vectors = 0;
  int miscompares = 0;

  mc_longop_sequencer dut (
    .Clk_pin(clk), .Resetn_pin(rst_n), .IW_in(iw_in), .IW_valid(iw_valid), .Flush(flush),
    .Stall(stall), .Busy(busy), .Unit_start(unit_start), .Unit_abort(unit_abort),
    .Unit_op(unit_op), .Unit_rd(unit_rd), .Unit_rs(unit_rs), .WB_en(wb_en), .WB_rd(wb_rd)
  );

  always #5 clk = ~clk;

  // Opcode table: index is the Unit_op code, latency with default parameters.
  logic [5:0] opc_tab [8] = '{6'b101010, 6'b101011, 6'b110010, 6'b110011,
                              6'b001000, 6'b001001, 6'b001010, 6'b001011};
  int         lat_tab [8] = '{4, 16, 4, 16, 3, 3, 5, 20};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [5:0] opc);
    for (int i = 0; i < 8; i++) if (opc_tab[i] == opc) return i;
    return -1;
  endfunction

  function automatic logic [15:0] mkiw(input logic [5:0] opc, input logic [4:0] ri, input logic [4:0] rj);
    return {opc, ri, rj};
  endfunction

  // Model: one op in flight, identified by accept cycle and latency.
  initial begin
    bit         m_inflight;
    int         m_tacc, m_lat, cyc, idx;
    logic [4:0] m_rd, m_rs;
    logic [2:0] m_op;
    bit         live, wb_now, acc, e_stall, e_wb;
    m_inflight = 1'b0; m_tacc = 0; m_lat = 0; cyc = 0;
    m_rd = 5'd0; m_rs = 5'd0; m_op = 3'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
        chk("rst_start", {31'd0, unit_start}, 32'd0);
        chk("rst_abort", {31'd0, unit_abort}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        m_inflight = 1'b0; m_rd = 5'd0; m_rs = 5'd0; m_op = 3'd0;
      end else begin
        live    = iw_valid && (iw_in != 16'hFFFF);
        idx     = lookup(iw_in[15:10]);
        wb_now  = m_inflight && (cyc == m_tacc + m_lat);
        acc     = !m_inflight && live && (idx >= 0) && !flush;
        e_stall = live && m_inflight &&
                  ((idx >= 0) || (iw_in[9:5] == m_rd) || (iw_in[4:0] == m_rd));
        e_wb    = wb_now && !flush;
        chk("m_busy", {31'd0, busy}, {31'd0, m_inflight});
        chk("m_stall", {31'd0, stall}, {31'd0, e_stall});
        chk("m_start", {31'd0, unit_start}, {31'd0, acc});
        chk("m_abort", {31'd0, unit_abort}, {31'd0, flush && m_inflight});
        chk("m_wb_en", {31'd0, wb_en}, {31'd0, e_wb});
        chk("m_wb_rd", {27'd0, wb_rd}, e_wb ? {27'd0, m_rd} : 32'd0);
        chk("m_op", {29'd0, unit_op}, acc ? 32'(idx) : {29'd0, m_op});
        chk("m_rd", {27'd0, unit_rd}, acc ? {27'd0, iw_in[9:5]} : {27'd0, m_rd});
        chk("m_rs", {27'd0, unit_rs}, acc ? {27'd0, iw_in[4:0]} : {27'd0, m_rs});
        if (m_inflight && (flush || wb_now)) m_inflight = 1'b0;
        if (acc) begin
          m_inflight = 1'b1; m_tacc = cyc; m_lat = lat_tab[idx];
          m_op = 3'(idx); m_rd = iw_in[9:5]; m_rs = iw_in[4:0];
        end
      end
      cyc++;
    end
  end

  task automatic step(input logic [15:0] iw, input logic v, input logic fl);
    @(posedge clk);
    #1;
    iw_in = iw; iw_valid = v; flush = fl;
    #1;
  endtask

  task automatic idle();
    step(16'h0000, 1'b0, 1'b0);
  endtask

  logic [5:0] extra_opc [4];
  int         extra_op  [4];

  initial begin
    rst_n = 1'b0; iw_in = 16'h0000; iw_valid = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_op", {29'd0, unit_op}, 32'd0);
    chk("reset_wb_rd", {27'd0, wb_rd}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // MUL R3,R4
    step(16'hA864, 1'b1, 1'b0);
    chk("mul_start", {31'd0, unit_start}, 32'd1);
    chk("mul_op", {29'd0, unit_op}, 32'd0);
    chk("mul_rd", {27'd0, unit_rd}, 32'd3);
    chk("mul_rs", {27'd0, unit_rs}, 32'd4);
    chk("mul_busy_t", {31'd0, busy}, 32'd0);
    idle();
    chk("mul_busy_t1", {31'd0, busy}, 32'd1);
    idle(); idle(); idle();
    chk("mul_wb_en", {31'd0, wb_en}, 32'd1);
    chk("mul_wb_rd", {27'd0, wb_rd}, 32'd3);
    chk("mul_busy_t4", {31'd0, busy}, 32'd1);
    idle();
    chk("mul_busy_t5", {31'd0, busy}, 32'd0);
    chk("mul_wb_off", {31'd0, wb_en}, 32'd0);

    // FDIV R1,R2 then unrelated ADD R5,R6
    step(mkiw(6'b001011, 5'd1, 5'd2), 1'b1, 1'b0);
    chk("fdiv_op", {29'd0, unit_op}, 32'd7);
    step(mkiw(6'b000001, 5'd5, 5'd6), 1'b1, 1'b0);
    chk("add_no_stall", {31'd0, stall}, 32'd0);
    repeat (18) idle();
    chk("fdiv_pre_wb", {31'd0, wb_en}, 32'd0);
    idle();
    chk("fdiv_wb_en", {31'd0, wb_en}, 32'd1);
    chk("fdiv_wb_rd", {27'd0, wb_rd}, 32'd1);
    idle();

    // FADD R7,R8 with dependent ADD R9,R7
    step(mkiw(6'b001000, 5'd7, 5'd8), 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      step(mkiw(6'b000001, 5'd9, 5'd7), 1'b1, 1'b0);
      chk("fadd_raw_stall", {31'd0, stall}, 32'd1);
    end
    chk("fadd_wb_en", {31'd0, wb_en}, 32'd1);
    step(mkiw(6'b000001, 5'd9, 5'd7), 1'b1, 1'b0);
    chk("fadd_stall_clear", {31'd0, stall}, 32'd0);
    idle();

    // DIV R2,R3 followed by a structural-hazard MUL R10,R11
    step(mkiw(6'b101011, 5'd2, 5'd3), 1'b1, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      step(mkiw(6'b101010, 5'd10, 5'd11), 1'b1, 1'b0);
      chk("div_struct_stall", {31'd0, stall}, 32'd1);
    end
    chk("div_wb_en", {31'd0, wb_en}, 32'd1);
    step(mkiw(6'b101010, 5'd10, 5'd11), 1'b1, 1'b0);
    chk("mul2_stall", {31'd0, stall}, 32'd0);
    chk("mul2_start", {31'd0, unit_start}, 32'd1);
    chk("mul2_rd", {27'd0, unit_rd}, 32'd10);
    repeat (5) idle();
    chk("mul2_done", {31'd0, busy}, 32'd0);

    // Flush of a DIV at t+2, then Flush with a MUL in IDLE
    step(mkiw(6'b101011, 5'd4, 5'd5), 1'b1, 1'b0);
    idle();
    step(16'h0000, 1'b0, 1'b1);
    chk("flush_abort", {31'd0, unit_abort}, 32'd1);
    chk("flush_no_start", {31'd0, unit_start}, 32'd0);
    idle();
    chk("flush_idle", {31'd0, busy}, 32'd0);
    chk("flush_abort_off", {31'd0, unit_abort}, 32'd0);
    repeat (20) idle();
    step(mkiw(6'b101010, 5'd1, 5'd2), 1'b1, 1'b1);
    chk("idle_flush_start", {31'd0, unit_start}, 32'd0);
    chk("idle_flush_abort", {31'd0, unit_abort}, 32'd0);
    idle();
    chk("idle_flush_busy", {31'd0, busy}, 32'd0);

    // Reset at t+5 of FDIV
    step(mkiw(6'b001011, 5'd1, 5'd2), 1'b1, 1'b0);
    repeat (4) idle();
    step(mkiw(6'b000001, 5'd1, 5'd1), 1'b1, 1'b0);
    chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_stall", {31'd0, stall}, 32'd0);
    chk("async_op", {29'd0, unit_op}, 32'd0);
    chk("async_rd", {27'd0, unit_rd}, 32'd0);
    chk("async_rs", {27'd0, unit_rs}, 32'd0);
    chk("async_wb", {31'd0, wb_en}, 32'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    repeat (25) idle();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Bubble word in IDLE and while busy
    step(16'hFFFF, 1'b1, 1'b0);
    chk("bubble_idle_start", {31'd0, unit_start}, 32'd0);
    chk("bubble_idle_stall", {31'd0, stall}, 32'd0);
    step(mkiw(6'b101010, 5'd31, 5'd0), 1'b1, 1'b0);
    step(16'hFFFF, 1'b1, 1'b0);
    chk("bubble_busy_stall", {31'd0, stall}, 32'd0);
    chk("bubble_busy", {31'd0, busy}, 32'd1);
    repeat (4) idle();
    chk("bubble_done", {31'd0, busy}, 32'd0);

    // Remaining opcodes: VMUL, VDIV, FSUB, FMUL
    extra_opc = '{6'b110010, 6'b110011, 6'b001001, 6'b001010};
    extra_op  = '{2, 3, 5, 6};
    for (int i = 0; i < 4; i++) begin
      step(mkiw(extra_opc[i], 5'(i + 12), 5'(i + 20)), 1'b1, 1'b0);
      chk("extra_op", {29'd0, unit_op}, 32'(extra_op[i]));
      repeat (lat_tab[extra_op[i]]) idle();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
